coherence_agent: RTL and testbench

Per-CPU MSI coherence controller. It is the cache-side end of the snooping bus protocol that the bus arbiter drives. It turns local data-cache accesses into read_miss/write_miss/invalidate bus requests and waits for grant and completion. It also answers bus snoops (cpu_search, cpu_datasel, invalidate_from_other_cpu) against its own tag/state directory. One instance sits between each cpu's D-cache and the shared bus.

---
 rtl/coherence_pkg.sv | 45 ++++
 rtl/coh_dir.sv | 60 ++++++
 rtl/coherence_agent.sv | 188 ++++++++++++++++++
 tb/tb_coherence_agent.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared types and geometry for the per-CPU MSI coherence agent.
package coherence_pkg;

  localparam int ADDR_W = 11;
  localparam int IDX_W  = 4;
  localparam int OFF_W  = 2;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  // MSI line states; 2'b11 is never written.
  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_e;

  // Kind of bus request the agent is carrying.
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_RD,
    REQ_WR,
    REQ_UPG,
    REQ_WB
  } req_e;

  // Agent controller states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VICTIM,
    ST_REQ,
    ST_WAIT
  } fsm_e;

  // One directory line.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    msi_e             state;
  } dir_entry_t;

  // Block-aligned bus address from tag and index.
  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/coh_dir.sv
// Tag/state directory: flop array with a local and a snoop read port and a
// single write port. A snoop write wins the port; a blocked local write is
// reported through loc_wack so the caller retries on the next cycle.
module coh_dir
  import coherence_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] loc_idx,
  output logic [TAG_W-1:0] loc_tag,
  output logic [1:0]       loc_state,
  input  logic [IDX_W-1:0] snp_idx,
  output logic [TAG_W-1:0] snp_tag,
  output logic [1:0]       snp_state,
  input  logic             snp_we,
  input  logic [1:0]       snp_wstate,
  input  logic             loc_we,
  input  logic [TAG_W-1:0] loc_wtag,
  input  logic [1:0]       loc_wstate,
  output logic             loc_wack
);

  localparam int DEPTH = 1 << IDX_W;

  dir_entry_t mem_q [DEPTH];
  dir_entry_t mem_d [DEPTH];

  // Combinational read ports.
  assign loc_tag   = mem_q[loc_idx].tag;
  assign loc_state = mem_q[loc_idx].state;
  assign snp_tag   = mem_q[snp_idx].tag;
  assign snp_state = mem_q[snp_idx].state;

  // Next directory contents: snoop state update first, otherwise local install.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    loc_wack = 1'b0;
    if (snp_we) begin
      mem_d[snp_idx].state = msi_e'(snp_wstate);
    end else if (loc_we) begin
      mem_d[loc_idx] = '{tag: loc_wtag, state: msi_e'(loc_wstate)};
      loc_wack       = 1'b1;
    end
  end

  // Directory register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose: a coherence directory must come up all-Invalid.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{tag: '0, state: MSI_I};
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/coherence_agent.sv
// Per-CPU MSI coherence agent: turns local D-cache misses into bus requests,
// handles modified-victim writeback, and answers bus snoops.
module coherence_agent
  import coherence_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic              read_miss,
  output logic              write_miss,
  output logic              invalidate,
  output logic              wback,
  output logic [ADDR_W-1:0] BICO,
  output logic [1:0]        block_state,
  input  logic              grant,
  input  logic              bus_done,
  input  logic              cpu_search,
  input  logic [ADDR_W-1:0] BOCI,
  output logic              cpu_search_found,
  input  logic              cpu_datasel,
  input  logic              invalidate_from_other_cpu
);

  fsm_e             state_q, state_d;
  req_e             req_q, req_d, req_eff;
  logic             gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             snp_valid_q, snp_valid_d;
  logic             snp_found_q, snp_found_d;
  logic [1:0]       snp_state_q, snp_state_d;

  logic [IDX_W-1:0] cpu_idx, boci_idx;
  logic [TAG_W-1:0] cpu_tag, boci_tag;
  logic [TAG_W-1:0] loc_tag, snp_tag, loc_wtag;
  logic [1:0]       loc_state, snp_state, loc_wstate, snp_wstate;
  logic             loc_hit, boci_hit, loc_we, loc_wack, snp_we, stall_c;
  logic             unused_off;

  assign cpu_idx    = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign boci_idx   = BOCI[OFF_W +: IDX_W];
  assign boci_tag   = BOCI[ADDR_W-1 -: TAG_W];
  assign unused_off = ^{cpu_addr[OFF_W-1:0], BOCI[OFF_W-1:0]};

  assign loc_hit  = (loc_state != MSI_I) && (loc_tag == cpu_tag);
  assign boci_hit = (snp_state != MSI_I) && (snp_tag == boci_tag);

  // Snoop-side directory updates: invalidate kills the line, datasel downgrades M to S.
  assign snp_we     = boci_hit && (invalidate_from_other_cpu ||
                                   (cpu_datasel && snp_state == MSI_M));
  assign snp_wstate = invalidate_from_other_cpu ? MSI_I : MSI_S;

  coh_dir u_dir (
    .clk        (clk),
    .rst_n      (rst_n),
    .loc_idx    (cpu_idx),
    .loc_tag    (loc_tag),
    .loc_state  (loc_state),
    .snp_idx    (boci_idx),
    .snp_tag    (snp_tag),
    .snp_state  (snp_state),
    .snp_we     (snp_we),
    .snp_wstate (snp_wstate),
    .loc_we     (loc_we),
    .loc_wtag   (loc_wtag),
    .loc_wstate (loc_wstate),
    .loc_wack   (loc_wack)
  );

  // Snoop lookup result, presented the cycle after cpu_search for one cycle.
  always_comb begin
    snp_valid_d = cpu_search;
    snp_found_d = cpu_search && boci_hit;
    snp_state_d = (cpu_search && boci_hit) ? snp_state : MSI_I;
  end

  // Controller next state, bus request drive and directory install requests.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    req_eff    = req_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    loc_we     = 1'b0;
    loc_wtag   = cpu_tag;
    loc_wstate = MSI_I;
    stall_c    = 1'b0;
    read_miss  = 1'b0;
    write_miss = 1'b0;
    invalidate = 1'b0;
    wback      = 1'b0;
    BICO       = '0;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = 1'b0;
        done_d = 1'b0;
        if ((cpu_re || cpu_we) && !(loc_hit && (!cpu_we || loc_state == MSI_M))) begin
          stall_c = 1'b1;
          if (loc_hit) begin
            req_d   = REQ_UPG;
            state_d = ST_REQ;
          end else begin
            req_d   = cpu_we ? REQ_WR : REQ_RD;
            state_d = (loc_state == MSI_M) ? ST_VICTIM : ST_REQ;
          end
        end
      end
      ST_VICTIM: begin
        stall_c = 1'b1;
        BICO    = block_addr(loc_tag, cpu_idx);
        if (loc_state != MSI_M) begin
          // A snoop took the victim away; start over from IDLE.
          state_d = ST_IDLE;
        end else begin
          wback = !gnt_q && !grant;
          if (grant) gnt_d = 1'b1;
          if (gnt_q && (bus_done || done_q)) begin
            loc_we   = 1'b1;
            loc_wtag = loc_tag;
            if (loc_wack) begin
              state_d = ST_REQ;
              gnt_d   = 1'b0;
              done_d  = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        BICO    = block_addr(cpu_tag, cpu_idx);
        // An upgrade whose S copy was invalidated must fetch the block instead.
        if (req_q == REQ_UPG && !loc_hit) req_eff = REQ_WR;
        req_d      = req_eff;
        read_miss  = (req_eff == REQ_RD)  && !grant;
        write_miss = (req_eff == REQ_WR)  && !grant;
        invalidate = (req_eff == REQ_UPG) && !grant;
        if (grant) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        BICO    = block_addr(cpu_tag, cpu_idx);
        if (bus_done || done_q) begin
          loc_we     = 1'b1;
          loc_wstate = (req_q == REQ_RD) ? MSI_S : MSI_M;
          if (loc_wack) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_stall        = stall_c && rst_n;
  assign cpu_search_found = snp_found_q;
  assign block_state      = snp_valid_q ? snp_state_q :
                            (state_q == ST_IDLE) ? MSI_I : loc_state;

  // Controller and snoop-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= REQ_NONE;
      gnt_q       <= 1'b0;
      done_q      <= 1'b0;
      snp_valid_q <= 1'b0;
      snp_found_q <= 1'b0;
      snp_state_q <= MSI_I;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      snp_valid_q <= snp_valid_d;
      snp_found_q <= snp_found_d;
      snp_state_q <= snp_state_d;
    end
  end

endmodule

// File: tb/tb_coherence_agent.sv
// Self-checking bench for coherence_agent: directed scenarios followed by
// random accesses and snoops, all checked against a line-level MSI model.
module tb_coherence_agent;
  import coherence_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic        cpu_stall, read_miss, write_miss, invalidate, wback;
  logic [10:0] BICO;
  logic [1:0]  block_state;
  logic        grant = 1'b0, bus_done = 1'b0, cpu_search = 1'b0;
  logic [10:0] BOCI = '0;
  logic        cpu_search_found;
  logic        cpu_datasel = 1'b0, invalidate_from_other_cpu = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per-line tag and state (0=I, 1=S, 2=M).
  int unsigned m_tag [16];
  int unsigned m_st  [16];

  localparam logic [3:0] K_RD  = 4'b0001;
  localparam logic [3:0] K_WR  = 4'b0010;
  localparam logic [3:0] K_UPG = 4'b0100;
  localparam logic [3:0] K_WB  = 4'b1000;

  coherence_agent dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .cpu_re                    (cpu_re),
    .cpu_we                    (cpu_we),
    .cpu_addr                  (cpu_addr),
    .cpu_stall                 (cpu_stall),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .wback                     (wback),
    .BICO                      (BICO),
    .block_state               (block_state),
    .grant                     (grant),
    .bus_done                  (bus_done),
    .cpu_search                (cpu_search),
    .BOCI                      (BOCI),
    .cpu_search_found          (cpu_search_found),
    .cpu_datasel               (cpu_datasel),
    .invalidate_from_other_cpu (invalidate_from_other_cpu)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] bus_req();
    return {wback, invalidate, write_miss, read_miss};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = 0;
      m_st[i]  = 0;
    end
  endtask

  // Wait (bounded) for a bus request and check kind/address while it is held.
  task automatic wait_req(input logic [3:0] kind, input logic [10:0] addr, input string tag);
    int n;
    n = 0;
    while (bus_req() == 4'b0 && n < 20) begin
      cyc();
      n++;
    end
    #1;
    check({tag, "_kind"}, bus_req(), kind);
    check({tag, "_bico"}, BICO, addr);
    if (kind == K_WB) check({tag, "_bstate"}, block_state, 2);
    repeat ($urandom_range(0, 2)) begin
      cyc();
      #1;
      check({tag, "_held"}, {bus_req(), BICO}, {kind, addr});
    end
  endtask

  // Grant the pending request, then complete it after a random delay.
  task automatic grant_done(input string tag);
    grant = 1'b1;
    cyc();
    grant = 1'b0;
    #1;
    check({tag, "_drop"}, bus_req(), 4'b0);
    repeat ($urandom_range(0, 2)) cyc();
    bus_done = 1'b1;
    #1;
    check({tag, "_busy"}, cpu_stall, 1);
    cyc();
    bus_done = 1'b0;
  endtask

  // One local access served by the bench acting as the bus.
  task automatic do_access(input bit wr, input logic [10:0] addr, input string tag);
    int unsigned idx, tg;
    bit hit;
    logic [4:0] vtag;
    logic [3:0] vidx;
    idx = addr[5:2];
    tg  = addr[10:6];
    hit = (m_st[idx] != 0) && (m_tag[idx] == tg);
    cpu_re = !wr;
    cpu_we = wr;
    cpu_addr = addr;
    #1;
    if (hit && (!wr || m_st[idx] == 2)) begin
      check({tag, "_hit_stall"}, cpu_stall, 0);
      check({tag, "_hit_noreq"}, bus_req(), 4'b0);
    end else begin
      check({tag, "_miss_stall"}, cpu_stall, 1);
      if (!hit && m_st[idx] == 2) begin
        vtag = m_tag[idx][4:0];
        vidx = idx[3:0];
        wait_req(K_WB, {vtag, vidx, 2'b00}, {tag, "_wb"});
        grant_done({tag, "_wb"});
        m_st[idx] = 0;
      end
      wait_req(hit ? K_UPG : (wr ? K_WR : K_RD), {addr[10:2], 2'b00}, {tag, "_req"});
      grant_done({tag, "_req"});
      m_tag[idx] = tg;
      m_st[idx]  = wr ? 2 : 1;
      #1;
      check({tag, "_release"}, cpu_stall, 0);
      check({tag, "_idle"}, bus_req(), 4'b0);
    end
    cyc();
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  // Snoop operation: 0 = search, 1 = datasel, 2 = invalidate.
  task automatic snoop(input int op, input logic [10:0] addr, input string tag);
    int unsigned idx, tg;
    bit hit;
    idx = addr[5:2];
    tg  = addr[10:6];
    hit = (m_st[idx] != 0) && (m_tag[idx] == tg);
    BOCI = addr;
    cpu_search  = (op == 0);
    cpu_datasel = (op == 1);
    invalidate_from_other_cpu = (op == 2);
    cyc();
    cpu_search  = 1'b0;
    cpu_datasel = 1'b0;
    invalidate_from_other_cpu = 1'b0;
    if (op == 0) begin
      #1;
      check({tag, "_found"}, cpu_search_found, hit);
      check({tag, "_bstate"}, block_state, hit ? m_st[idx] : 0);
      cyc();
      #1;
      check({tag, "_found_clr"}, cpu_search_found, 0);
    end else if (op == 1) begin
      if (hit && m_st[idx] == 2) m_st[idx] = 1;
    end else begin
      if (hit) m_st[idx] = 0;
    end
  endtask

  initial begin
    logic [4:0]  rtag;
    logic [3:0]  ridx;
    logic [1:0]  roff;
    logic [10:0] raddr;
    int          rop;

    model_reset();
    #12;
    check("reset_outputs",
          {cpu_stall, read_miss, write_miss, invalidate, wback, BICO, block_state, cpu_search_found}, '0);
    rst_n = 1'b1;
    cyc();

    // Cold read, then a hit in the same block.
    do_access(1'b0, 11'h084, "cold_rd");
    do_access(1'b0, 11'h085, "rd_hit");
    // Upgrade S->M, then a write hit.
    do_access(1'b1, 11'h084, "upg");
    do_access(1'b1, 11'h086, "wr_hit");
    // Conflict with a modified victim.
    do_access(1'b0, 11'h484, "victim");
    do_access(1'b1, 11'h084, "wr_miss");

    // Snoop sequence on a modified line.
    snoop(0, 11'h084, "snp_m");
    snoop(1, 11'h084, "snp_dsel");
    snoop(0, 11'h084, "snp_s");
    snoop(2, 11'h084, "snp_inv");
    snoop(0, 11'h084, "snp_i");

    // Upgrade race: invalidated before grant turns into a write miss.
    do_access(1'b0, 11'h084, "race_fill");
    cpu_we = 1'b1;
    cpu_addr = 11'h084;
    #1;
    check("race_stall", cpu_stall, 1);
    wait_req(K_UPG, 11'h084, "race_upg");
    BOCI = 11'h084;
    invalidate_from_other_cpu = 1'b1;
    cyc();
    invalidate_from_other_cpu = 1'b0;
    #1;
    check("race_conv", bus_req(), K_WR);
    check("race_bico", BICO, 11'h084);
    grant_done("race");
    m_st[1] = 2;
    #1;
    check("race_release", cpu_stall, 0);
    cyc();
    cpu_we = 1'b0;
    snoop(0, 11'h084, "race_m");

    // Reset in the middle of a transaction.
    cpu_re = 1'b1;
    cpu_addr = 11'h100;
    wait_req(K_RD, 11'h100, "rst_req");
    grant = 1'b1;
    cyc();
    grant = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_outputs",
          {cpu_stall, read_miss, write_miss, invalidate, wback, BICO, block_state, cpu_search_found}, '0);
    cpu_re = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    cyc();
    do_access(1'b0, 11'h084, "post_rst");

    // Random accesses and snoops over a small, conflict-heavy address set.
    for (int i = 0; i < 80; i++) begin
      rtag  = 5'($urandom_range(0, 3));
      ridx  = 4'($urandom_range(0, 3));
      roff  = 2'($urandom_range(0, 3));
      raddr = {rtag, ridx, roff};
      rop   = $urandom_range(0, 6);
      case (rop)
        0, 1:    do_access(1'b0, raddr, "rnd_rd");
        2, 3:    do_access(1'b1, raddr, "rnd_wr");
        4:       snoop(0, raddr, "rnd_srch");
        5:       snoop(1, raddr, "rnd_dsel");
        default: snoop(2, raddr, "rnd_inv");
      endcase
    end

    // Final sweep of the lines touched by the random phase.
    for (int t = 0; t < 4; t++) begin
      for (int x = 0; x < 4; x++) begin
        rtag = 5'(t);
        ridx = 4'(x);
        snoop(0, {rtag, ridx, 2'b00}, "sweep");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
